// File: rtl/wb_arbiter_pkg.sv
// Shared constants for the writeback arbiter slice.
// ROB sizing and completion-source slot indices.
package wb_arbiter_pkg;

  localparam int ROB_SIZE = 16;
  localparam int ROB_TAGW = $clog2(ROB_SIZE);

  localparam int SRC_ALU1  = 0;
  localparam int SRC_ALU2  = 1;
  localparam int SRC_LOAD  = 2;
  localparam int SRC_STORE = 3;
  localparam int SRC_NUM   = 4;

  localparam int DATAW = 32;

endpackage

// File: rtl/wb_rr_pick2.sv
// Round-robin picker: up to two occupied slots from rr onward.
// Produces one-hot grants and the pointer after the last grant.
module wb_rr_pick2 #(
  parameter int NSRC = 4,
  parameter int RRW  = 2
) (
  input  logic [NSRC-1:0] occ,
  input  logic [RRW-1:0]  rr,
  output logic [NSRC-1:0] gnt0,
  output logic [NSRC-1:0] gnt1,
  output logic            any0,
  output logic            any1,
  output logic [RRW-1:0]  rr_next
);

  function automatic logic [RRW-1:0] wrap_inc(
    input logic [RRW-1:0] v
  );
    logic [RRW:0] s;
    s = {1'b0, v} + (RRW+1)'(1);
    if (s >= (RRW+1)'(NSRC))
      s = s - (RRW+1)'(NSRC);
    return s[RRW-1:0];
  endfunction

  always_comb begin
    logic [RRW:0]   sum;
    logic [RRW-1:0] idx;
    gnt0    = '0;
    gnt1    = '0;
    any0    = 1'b0;
    any1    = 1'b0;
    rr_next = rr;
    sum     = '0;
    idx     = '0;
    for (int k = 0; k < NSRC; k++) begin
      sum = {1'b0, rr} + (RRW+1)'(k);
      if (sum >= (RRW+1)'(NSRC))
        sum = sum - (RRW+1)'(NSRC);
      idx = sum[RRW-1:0];
      if (occ[idx]) begin
        if (!any0) begin
          gnt0[idx] = 1'b1;
          any0      = 1'b1;
          rr_next   = wrap_inc(idx);
        end else if (!any1) begin
          gnt1[idx] = 1'b1;
          any1      = 1'b1;
          rr_next   = wrap_inc(idx);
        end
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Completion-to-ROB writeback arbiter: per-source hold registers
// drained two per cycle in round-robin order.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int NSRC = SRC_NUM,
  parameter int TAGW = ROB_TAGW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              flush,
  input  logic [NSRC-1:0]   src_valid,
  input  logic [NSRC*TAGW-1:0] src_tag,
  input  logic [NSRC*32-1:0]   src_data,
  output logic [NSRC-1:0]   src_ready,
  output logic              wb0_valid,
  output logic [TAGW-1:0]   wb0_tag,
  output logic [31:0]       wb0_data,
  output logic              wb1_valid,
  output logic [TAGW-1:0]   wb1_tag,
  output logic [31:0]       wb1_data
);

  localparam int RRW = (NSRC > 1) ? $clog2(NSRC) : 1;

  logic [NSRC-1:0] hold_vld;
  logic [TAGW-1:0] hold_tag  [NSRC];
  logic [31:0]     hold_data [NSRC];
  logic [RRW-1:0]  rr;

  logic [NSRC-1:0] gnt0;
  logic [NSRC-1:0] gnt1;
  logic            any0;
  logic            any1;
  logic [RRW-1:0]  rr_next;

  logic [TAGW-1:0] sel0_tag;
  logic [TAGW-1:0] sel1_tag;
  logic [31:0]     sel0_data;
  logic [31:0]     sel1_data;

  // Ready depends only on registered occupancy.
  assign src_ready = ~hold_vld;

  wb_rr_pick2 #(
    .NSRC (NSRC),
    .RRW  (RRW)
  ) u_pick (
    .occ     (hold_vld),
    .rr      (rr),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .any0    (any0),
    .any1    (any1),
    .rr_next (rr_next)
  );

  always_comb begin
    sel0_tag  = '0;
    sel1_tag  = '0;
    sel0_data = '0;
    sel1_data = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (gnt0[i]) begin
        sel0_tag  = sel0_tag  | hold_tag[i];
        sel0_data = sel0_data | hold_data[i];
      end
      if (gnt1[i]) begin
        sel1_tag  = sel1_tag  | hold_tag[i];
        sel1_data = sel1_data | hold_data[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_vld  <= '0;
      for (int i = 0; i < NSRC; i++) begin
        hold_tag[i]  <= '0;
        hold_data[i] <= '0;
      end
      wb0_valid <= 1'b0;
      wb0_tag   <= '0;
      wb0_data  <= '0;
      wb1_valid <= 1'b0;
      wb1_tag   <= '0;
      wb1_data  <= '0;
      rr        <= '0;
    end else if (rdy) begin
      if (flush) begin
        hold_vld  <= '0;
        wb0_valid <= 1'b0;
        wb1_valid <= 1'b0;
        rr        <= '0;
      end else begin
        for (int i = 0; i < NSRC; i++) begin
          if (gnt0[i] || gnt1[i]) begin
            hold_vld[i] <= 1'b0;
          end else if (src_valid[i] && !hold_vld[i]) begin
            hold_vld[i]  <= 1'b1;
            hold_tag[i]  <= src_tag[i*TAGW +: TAGW];
            hold_data[i] <= src_data[i*32 +: 32];
          end
        end
        wb0_valid <= any0;
        wb1_valid <= any1;
        if (any0) begin
          wb0_tag  <= sel0_tag;
          wb0_data <= sel0_data;
          rr       <= rr_next;
        end
        if (any1) begin
          wb1_tag  <= sel1_tag;
          wb1_data <= sel1_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus
// randomized traffic against a queue-based reference model.
module tb_wb_arbiter;

  logic         clk;
  logic         rst;
  logic         rdy;
  logic         flush;
  logic [3:0]   src_valid;
  logic [15:0]  src_tag;
  logic [127:0] src_data;
  logic [3:0]   src_ready;
  logic         wb0_valid;
  logic [3:0]   wb0_tag;
  logic [31:0]  wb0_data;
  logic         wb1_valid;
  logic [3:0]   wb1_tag;
  logic [31:0]  wb1_data;

  int checks;
  int failures;

  bit [3:0]  m_full;
  bit [3:0]  m_tag  [4];
  bit [31:0] m_data [4];
  int        m_rr;
  bit        m_wb0v;
  bit        m_wb1v;
  bit [3:0]  m_wb0t;
  bit [3:0]  m_wb1t;
  bit [31:0] m_wb0d;
  bit [31:0] m_wb1d;

  wb_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .flush     (flush),
    .src_valid (src_valid),
    .src_tag   (src_tag),
    .src_data  (src_data),
    .src_ready (src_ready),
    .wb0_valid (wb0_valid),
    .wb0_tag   (wb0_tag),
    .wb0_data  (wb0_data),
    .wb1_valid (wb1_valid),
    .wb1_tag   (wb1_tag),
    .wb1_data  (wb1_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: walk slots from rr, take the first two occupied.
  task automatic model_edge();
    int picks[$];
    bit [3:0] cap;
    if (rst) begin
      m_full = '0;
      m_wb0v = 0; m_wb1v = 0;
      m_wb0t = 0; m_wb1t = 0;
      m_wb0d = 0; m_wb1d = 0;
      m_rr   = 0;
    end else if (rdy) begin
      if (flush) begin
        m_full = '0;
        m_wb0v = 0;
        m_wb1v = 0;
        m_rr   = 0;
      end else begin
        for (int k = 0; k < 4; k++) begin
          int idx;
          idx = (m_rr + k) % 4;
          if (m_full[idx] && picks.size() < 2)
            picks.push_back(idx);
        end
        cap = ~m_full & src_valid;
        m_wb0v = picks.size() > 0;
        m_wb1v = picks.size() > 1;
        if (m_wb0v) begin
          m_wb0t = m_tag[picks[0]];
          m_wb0d = m_data[picks[0]];
          m_full[picks[0]] = 0;
        end
        if (m_wb1v) begin
          m_wb1t = m_tag[picks[1]];
          m_wb1d = m_data[picks[1]];
          m_full[picks[1]] = 0;
        end
        if (picks.size() > 0)
          m_rr = (picks[picks.size()-1] + 1) % 4;
        for (int i = 0; i < 4; i++) begin
          if (cap[i]) begin
            m_full[i] = 1;
            m_tag[i]  = src_tag[i*4 +: 4];
            m_data[i] = src_data[i*32 +: 32];
          end
        end
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; rdy = 1; flush = 0;
    src_valid = '0; src_tag = '0; src_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (src_ready !== 4'hF) begin
      failures++;
      $display("FAIL reset_ready got=%h exp=f", src_ready);
    end
    checks++;
    if ({wb0_valid, wb1_valid} !== 2'b00) begin
      failures++;
      $display("FAIL reset_valid got=%b exp=00", {wb0_valid, wb1_valid});
    end
    checks++;
    if ({wb0_tag, wb0_data, wb1_tag, wb1_data} !== '0) begin
      failures++;
      $display("FAIL reset_tagdata got=%h/%h %h/%h exp=0",
               wb0_tag, wb0_data, wb1_tag, wb1_data);
    end
    checks++;
    if (dut.rr !== 2'd0) begin
      failures++;
      $display("FAIL reset_rr got=%0d exp=0", dut.rr);
    end
  endtask

  task automatic test_single();
    do_reset();
    src_valid = 4'b0001;
    src_tag[3:0] = 4'd5;
    src_data[31:0] = 32'hDEADBEEF;
    tick();
    idle_inputs();
    checks++;
    if (src_ready !== 4'b1110) begin
      failures++;
      $display("FAIL single_accept got=%b exp=1110", src_ready);
    end
    tick();
    checks++;
    if ({wb0_valid, wb0_tag, wb0_data, wb1_valid} !==
        {1'b1, 4'd5, 32'hDEADBEEF, 1'b0}) begin
      failures++;
      $display("FAIL single_wb got=%b/%0d/%h/%b exp=1/5/deadbeef/0",
               wb0_valid, wb0_tag, wb0_data, wb1_valid);
    end
    checks++;
    if (dut.rr !== 2'd1) begin
      failures++;
      $display("FAIL single_rr got=%0d exp=1", dut.rr);
    end
    tick();
    checks++;
    if ({wb0_valid, wb1_valid} !== 2'b00) begin
      failures++;
      $display("FAIL single_drain got=%b exp=00", {wb0_valid, wb1_valid});
    end
  endtask

  task automatic test_all_four();
    logic [31:0] d [4];
    do_reset();
    for (int i = 0; i < 4; i++) begin
      d[i] = $urandom;
      src_tag[i*4 +: 4] = 4'(i + 1);
      src_data[i*32 +: 32] = d[i];
    end
    src_valid = 4'hF;
    tick();
    idle_inputs();
    tick();
    checks++;
    if ({wb0_valid, wb0_tag, wb1_valid, wb1_tag} !==
        {1'b1, 4'd1, 1'b1, 4'd2}) begin
      failures++;
      $display("FAIL four_c1 got=%b/%0d %b/%0d exp=1/1 1/2",
               wb0_valid, wb0_tag, wb1_valid, wb1_tag);
    end
    checks++;
    if ({wb0_data, wb1_data} !== {d[0], d[1]}) begin
      failures++;
      $display("FAIL four_c1_data got=%h %h exp=%h %h",
               wb0_data, wb1_data, d[0], d[1]);
    end
    tick();
    checks++;
    if ({wb0_valid, wb0_tag, wb1_valid, wb1_tag} !==
        {1'b1, 4'd3, 1'b1, 4'd4}) begin
      failures++;
      $display("FAIL four_c2 got=%b/%0d %b/%0d exp=1/3 1/4",
               wb0_valid, wb0_tag, wb1_valid, wb1_tag);
    end
    checks++;
    if ({wb0_data, wb1_data} !== {d[2], d[3]}) begin
      failures++;
      $display("FAIL four_c2_data got=%h %h exp=%h %h",
               wb0_data, wb1_data, d[2], d[3]);
    end
    checks++;
    if (src_ready !== 4'hF) begin
      failures++;
      $display("FAIL four_ready got=%b exp=1111", src_ready);
    end
  endtask

  task automatic test_continuous();
    int last [4];
    int maxgap [4];
    int cnt [4];
    logic [3:0] exp_rdy;
    do_reset();
    src_valid = 4'hF;
    for (int c = 1; c <= 21; c++) begin
      for (int i = 0; i < 4; i++) begin
        src_tag[i*4 +: 4] = {2'(c), 2'(i)};
        src_data[i*32 +: 32] = $urandom;
      end
      tick();
      exp_rdy = ~m_full;
      checks++;
      if ({wb0_valid, wb1_valid, src_ready} !==
          {m_wb0v, m_wb1v, exp_rdy}) begin
        failures++;
        $display("FAIL cont_ctl c=%0d got=%b%b/%b exp=%b%b/%b", c,
                 wb0_valid, wb1_valid, src_ready,
                 m_wb0v, m_wb1v, exp_rdy);
      end
      if (m_wb0v) begin
        checks++;
        if ({wb0_tag, wb0_data} !== {m_wb0t, m_wb0d}) begin
          failures++;
          $display("FAIL cont_wb0 c=%0d got=%h/%h exp=%h/%h", c,
                   wb0_tag, wb0_data, m_wb0t, m_wb0d);
        end
      end
      if (m_wb1v) begin
        checks++;
        if ({wb1_tag, wb1_data} !== {m_wb1t, m_wb1d}) begin
          failures++;
          $display("FAIL cont_wb1 c=%0d got=%h/%h exp=%h/%h", c,
                   wb1_tag, wb1_data, m_wb1t, m_wb1d);
        end
      end
      if (c == 1) begin
        for (int i = 0; i < 4; i++) begin
          last[i] = 1; maxgap[i] = 0; cnt[i] = 0;
        end
      end else begin
        for (int p = 0; p < 2; p++) begin
          logic v;
          logic [1:0] s;
          v = (p == 0) ? wb0_valid : wb1_valid;
          s = (p == 0) ? wb0_tag[1:0] : wb1_tag[1:0];
          if (v) begin
            if (c - last[s] > maxgap[s]) maxgap[s] = c - last[s];
            last[s] = c;
            cnt[s]++;
          end
        end
      end
    end
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (maxgap[i] > 2 || maxgap[i] < 1 || cnt[i] < 9) begin
        failures++;
        $display("FAIL cont_starve src=%0d gap=%0d grants=%0d exp=gap<=2 grants>=9",
                 i, maxgap[i], cnt[i]);
      end
    end
  endtask

  task automatic test_flush();
    do_reset();
    src_valid = 4'b0100;
    src_tag[11:8] = 4'd9;
    src_data[95:64] = 32'h1234_5678;
    tick();
    src_valid = 4'b0010;
    src_tag = '0;
    src_tag[7:4] = 4'd6;
    flush = 1;
    tick();
    idle_inputs();
    checks++;
    if ({wb0_valid, wb1_valid, src_ready} !== {2'b00, 4'hF}) begin
      failures++;
      $display("FAIL flush_state got=%b%b/%b exp=00/1111",
               wb0_valid, wb1_valid, src_ready);
    end
    checks++;
    if (dut.rr !== 2'd0) begin
      failures++;
      $display("FAIL flush_rr got=%0d exp=0", dut.rr);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({wb0_valid, wb1_valid} !== 2'b00) begin
        failures++;
        $display("FAIL flush_leak k=%0d got=%b%b exp=00",
                 k, wb0_valid, wb1_valid);
      end
    end
  endtask

  task automatic test_rdy_hold();
    do_reset();
    src_valid = 4'b0001;
    src_tag = 16'h0007;
    tick();
    src_valid = 4'b1110;
    src_tag = {4'hC, 4'hB, 4'hA, 4'h0};
    tick();
    rdy = 0;
    flush = 1;
    src_valid = 4'hF;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({wb0_valid, wb0_tag, wb1_valid, src_ready} !==
          {1'b1, 4'd7, 1'b0, 4'b0001} || dut.rr !== 2'd1) begin
        failures++;
        $display("FAIL rdy_freeze k=%0d got=%b/%0d/%b/%b rr=%0d exp=1/7/0/0001 rr=1",
                 k, wb0_valid, wb0_tag, wb1_valid, src_ready, dut.rr);
      end
    end
    idle_inputs();
    tick();
    checks++;
    if ({wb0_valid, wb0_tag, wb1_valid, wb1_tag} !==
        {1'b1, 4'hA, 1'b1, 4'hB}) begin
      failures++;
      $display("FAIL rdy_resume1 got=%b/%h %b/%h exp=1/a 1/b",
               wb0_valid, wb0_tag, wb1_valid, wb1_tag);
    end
    tick();
    checks++;
    if ({wb0_valid, wb0_tag, wb1_valid} !== {1'b1, 4'hC, 1'b0}) begin
      failures++;
      $display("FAIL rdy_resume2 got=%b/%h %b exp=1/c 0",
               wb0_valid, wb0_tag, wb1_valid);
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    src_valid = 4'b0011;
    src_tag = 16'h0043;
    src_data = {64'h0, 32'h4444_4444, 32'h3333_3333};
    tick();
    idle_inputs();
    rst = 1;
    flush = 1;
    tick();
    rst = 0;
    flush = 0;
    checks++;
    if ({wb0_valid, wb1_valid, wb0_tag, wb1_tag, wb0_data, wb1_data,
         src_ready} !== {2'b00, 72'h0, 4'hF}) begin
      failures++;
      $display("FAIL rst_mid got=%b%b %h/%h %h/%h rdy=%b exp=all 0 rdy=1111",
               wb0_valid, wb1_valid, wb0_tag, wb1_tag,
               wb0_data, wb1_data, src_ready);
    end
    tick();
    checks++;
    if ({wb0_valid, wb1_valid} !== 2'b00) begin
      failures++;
      $display("FAIL rst_mid_leak got=%b%b exp=00", wb0_valid, wb1_valid);
    end
  endtask

  task automatic test_random();
    logic [3:0] exp_rdy;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(99) < 2);
      rdy = ($urandom_range(99) < 80);
      flush = ($urandom_range(99) < 5);
      src_valid = 4'($urandom);
      src_tag = 16'($urandom);
      src_data = {$urandom, $urandom, $urandom, $urandom};
      tick();
      exp_rdy = ~m_full;
      checks++;
      if ({wb0_valid, wb1_valid, src_ready} !==
          {m_wb0v, m_wb1v, exp_rdy} || dut.rr !== 2'(m_rr)) begin
        failures++;
        $display("FAIL rand_ctl c=%0d got=%b%b/%b rr=%0d exp=%b%b/%b rr=%0d",
                 c, wb0_valid, wb1_valid, src_ready, dut.rr,
                 m_wb0v, m_wb1v, exp_rdy, m_rr);
      end
      if (m_wb0v) begin
        checks++;
        if ({wb0_tag, wb0_data} !== {m_wb0t, m_wb0d}) begin
          failures++;
          $display("FAIL rand_wb0 c=%0d got=%h/%h exp=%h/%h", c,
                   wb0_tag, wb0_data, m_wb0t, m_wb0d);
        end
      end
      if (m_wb1v) begin
        checks++;
        if ({wb1_tag, wb1_data} !== {m_wb1t, m_wb1d}) begin
          failures++;
          $display("FAIL rand_wb1 c=%0d got=%h/%h exp=%h/%h", c,
                   wb1_tag, wb1_data, m_wb1t, m_wb1d);
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    m_full = '0;
    m_rr = 0;
    idle_inputs();
    test_reset();
    test_single();
    test_all_four();
    test_continuous();
    test_flush();
    test_rdy_hold();
    test_reset_midflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
